// File: rtl/seq_div_signed.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, with sign correction applied in a final FIX cycle.
// Start/done handshake; results and flags hold until the next operation completes.
module seq_div_signed #(
  parameter int N = 8,
  parameter int M = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] A,
  input  logic signed [M-1:0] B,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] Quot,
  output logic signed [M-1:0] Rem,
  output logic                div_by_zero,
  output logic                ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // Most-negative dividend; divided by -1 it is the one quotient that cannot be represented.
  localparam logic [N-1:0] A_MIN = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic          sa;
  logic          sb;
  logic          ovf_pend;
  logic [M-1:0]  mag_b;
  logic [M:0]    part;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;

  logic [M:0]    part_sh;
  logic [M:0]    part_diff;
  logic          part_ge;

  // Apply the quotient sign; negation wraps modulo 2^N, so -2^(N-1) maps to itself.
  function automatic logic [N-1:0] fix_quot(input logic [N-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Apply the dividend's sign to the remainder magnitude. The partial remainder
  // always ends below |B| <= 2^(M-1), so truncating to M bits loses nothing.
  function automatic logic [M-1:0] fix_rem(input logic [M:0] mag, input logic neg);
    return M'(neg ? (~mag + 1'b1) : mag);
  endfunction

  // One restoring step: shift the next dividend bit (held at the top of q) into
  // the partial remainder and trial-subtract |B|.
  always_comb begin
    part_sh   = {part[M-1:0], q[N-1]};
    part_diff = part_sh - {1'b0, mag_b};
    part_ge   = (part_sh >= {1'b0, mag_b});
  end

  // Control FSM and datapath registers: accept in IDLE, N steps in CALC, sign fix and done in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sa          <= 1'b0;
      sb          <= 1'b0;
      ovf_pend    <= 1'b0;
      mag_b       <= '0;
      part        <= '0;
      q           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Quot        <= '0;
      Rem         <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa       <= A[N-1];
            sb       <= B[M-1];
            // q starts as |A| and is shifted out MSB-first while quotient bits shift in.
            q        <= A[N-1] ? (~A + 1'b1) : A;
            // -2^(M-1) negates to 2^(M-1), which still fits as an M-bit magnitude.
            mag_b    <= B[M-1] ? (~B + 1'b1) : B;
            ovf_pend <= (A == A_MIN) && (B == '1);
            part     <= '0;
            cnt      <= CW'(N - 1);
            busy     <= 1'b1;
            state    <= (B == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          part <= part_ge ? part_diff : part_sh;
          q    <= {q[N-2:0], part_ge};
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (mag_b == '0) begin
            Quot        <= '1;
            Rem         <= '0;
            div_by_zero <= 1'b1;
            ovf         <= 1'b0;
          end else begin
            Quot        <= fix_quot(q, sa ^ sb);
            Rem         <= fix_rem(part, sa);
            div_by_zero <= 1'b0;
            ovf         <= ovf_pend;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_signed.sv
// Self-checking bench for seq_div_signed (N=8, M=5): directed cases followed by
// random operands, compared against an integer-arithmetic reference model.
module tb_seq_div_signed;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [4:0] B;
  logic       busy;
  logic       done;
  logic [7:0] Quot;
  logic [4:0] Rem;
  logic       div_by_zero;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_div_signed #(.N(8), .M(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Quot(Quot), .Rem(Rem),
    .div_by_zero(div_by_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer division (truncating) with the two special cases.
  task automatic model(input logic [7:0] a, input logic [4:0] b,
                       output logic [7:0] eq, output logic [4:0] er,
                       output logic ez, output logic eo, output int elat);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    ez = 1'b0;
    eo = 1'b0;
    elat = 9;
    if (bi == 0) begin
      eq = 8'hFF; er = 5'd0; ez = 1'b1; elat = 1;
    end else if (ai == -128 && bi == -1) begin
      eq = 8'h80; er = 5'd0; eo = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      eq = qi[7:0];
      er = ri[4:0];
    end
  endtask

  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one operation from an idle negedge; returns at the negedge where done is visible.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [4:0] b);
    logic [7:0] eq;
    logic [4:0] er;
    logic ez, eo;
    int elat, lat;
    model(a, b, eq, er, ez, eo, elat);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom);
    B = 5'($urandom);
    chk({tag, ".busy_hi"}, busy, 1);
    lat = 0;
    wait_done(lat);
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".quot"}, Quot, eq);
    chk({tag, ".rem"}, Rem, er);
    chk({tag, ".dbz"}, div_by_zero, ez);
    chk({tag, ".ovf"}, ovf, eo);
    chk({tag, ".busy_lo"}, busy, 0);
  endtask

  initial begin
    int lat;
    logic seen_done;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.quot", Quot, 0);
    chk("rst.rem", Rem, 0);
    chk("rst.dbz", div_by_zero, 0);
    chk("rst.ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 8'h9C, 5'd7);
    chk("t1.quot_const", Quot, 8'hF2);
    chk("t1.rem_const", Rem, 5'h1E);
    repeat (3) @(negedge clk);
    chk("t1.hold_quot", Quot, 8'hF2);
    chk("t1.hold_rem", Rem, 5'h1E);
    chk("t1.done_pulse", done, 0);

    run_op("t2a", 8'd100, 5'h19);
    @(negedge clk);
    run_op("t2b", 8'h9C, 5'h19);
    chk("t2b.quot_const", Quot, 8'h0E);
    @(negedge clk);
    run_op("t2c", 8'd5, 5'd9);
    @(negedge clk);

    run_op("t3a", 8'h80, 5'h1F);
    chk("t3a.ovf_const", ovf, 1);
    @(negedge clk);
    run_op("t3b", 8'd127, 5'h10);
    chk("t3b.quot_const", Quot, 8'hF9);
    @(negedge clk);

    run_op("t4", 8'd37, 5'd0);
    chk("t4.quot_const", Quot, 8'hFF);
    @(negedge clk);

    // Second start while busy must be ignored.
    A = 8'd100; B = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    repeat (3) begin @(negedge clk); lat++; end
    A = 8'd50; B = 5'd3; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    wait_done(lat);
    chk("t5.latency", lat, 9);
    chk("t5.quot", Quot, 8'd14);
    chk("t5.rem", Rem, 5'd2);
    // Restart on the first idle edge after done.
    run_op("t5.restart", 8'd50, 5'd3);
    chk("t5.restart_quot", Quot, 8'd16);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    A = 8'd100; B = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.busy", busy, 0);
    chk("t6.done", done, 0);
    chk("t6.quot", Quot, 0);
    chk("t6.rem", Rem, 0);
    chk("t6.dbz", div_by_zero, 0);
    chk("t6.ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    chk("t6.no_done", seen_done, 0);
    run_op("t6.after", 8'd21, 5'h1C);
    chk("t6.after_quot", Quot, 8'hFB);
    chk("t6.after_rem", Rem, 5'd1);

    // Random operands, with occasional forced corner values and idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [4:0] rb;
      ra = 8'($urandom);
      rb = 5'($urandom);
      if (i % 10 == 3) rb = 5'h10;
      if (i % 10 == 7) ra = 8'h80;
      if (i % 13 == 5) rb = 5'd0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op("rnd", ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
